// File: rtl/exibicao_pkg.sv
// Shared state codes for the sequence playback unit; the game control unit
// decodes db_estado with these same constants.
package exibicao_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        AVANCA  = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'hF;

    // Timer only ever reaches max(T_ON,T_OFF)-1; keep at least one bit.
    function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/contador_tempo.sv
// Up-counter with synchronous clear and a flag raised when it equals a given value.
module contador_tempo #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             zera_i,
    input  logic             conta_i,
    input  logic [WIDTH-1:0] valor_fim_i,
    output logic             fim_o
);

    logic [WIDTH-1:0] contagem_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            contagem_q <= '0;
        end else if (zera_i) begin
            contagem_q <= '0;
        end else if (conta_i) begin
            contagem_q <= contagem_q + WIDTH'(1);
        end
    end

    assign fim_o = (contagem_q == valor_fim_i);

endmodule

// File: rtl/controle_exibicao_sequencia.sv
// Plays the stored pattern sequence (addresses 0..limite) onto the LEDs,
// T_ON cycles lit and T_OFF cycles blank per item, then pulses pronto.
module controle_exibicao_sequencia
    import exibicao_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned T_ON   = 500,
    parameter int unsigned T_OFF  = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ativo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int unsigned   TW      = largura_timer(T_ON, T_OFF);
    localparam logic [TW-1:0] FIM_ON  = TW'(T_ON - 1);
    localparam logic [TW-1:0] FIM_OFF = TW'(T_OFF - 1);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] limite_q, limite_d;
    logic              zera, conta, timer_fim;
    logic [TW-1:0]     valor_fim;

    contador_tempo #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i       (clock),
        .rst_n_i     (reset),
        .zera_i      (zera),
        .conta_i     (conta),
        .valor_fim_i (valor_fim),
        .fim_o       (timer_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            limite_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        zera       = 1'b0;
        conta      = 1'b0;
        valor_fim  = FIM_ON;
        leds       = '0;
        ativo      = 1'b0;
        pronto     = 1'b0;
        db_estado  = 4'(estado_q);

        case (estado_q)
            OCIOSO: begin
                if (iniciar) estado_d = CARREGA;
            end
            CARREGA: begin
                ativo      = 1'b1;
                limite_d   = limite;
                endereco_d = '0;
                zera       = 1'b1;
                estado_d   = ACENDE;
            end
            ACENDE: begin
                ativo = 1'b1;
                leds  = dado_memoria;
                conta = 1'b1;
                if (timer_fim) begin
                    zera     = 1'b1;
                    estado_d = APAGA;
                end
            end
            APAGA: begin
                ativo     = 1'b1;
                conta     = 1'b1;
                valor_fim = FIM_OFF;
                if (timer_fim) begin
                    zera     = 1'b1;
                    estado_d = (endereco_q == limite_q) ? FIM : AVANCA;
                end
            end
            AVANCA: begin
                ativo      = 1'b1;
                endereco_d = endereco_q + ADDR_W'(1);
                zera       = 1'b1;
                estado_d   = ACENDE;
            end
            FIM: begin
                pronto   = 1'b1;
                estado_d = OCIOSO;
            end
            default: begin
                db_estado = DB_ILEGAL;
                estado_d  = OCIOSO;
            end
        endcase
    end

    assign endereco = endereco_q;

endmodule
